clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Memory-mapped core-local interruptor (CLINT) register block. Sits on the data-memory bus beside the data RAM.
- Holds the machine timer (mtime), the timer compare register (mtimecmp) and the software-interrupt bit (msip).
- Drives the timer and software interrupt requests to the trap/CSR path, which takes them and redirects the PC.
- Is the interrupt source for the trap path, which handles the interrupts.

Parameters:
- XLEN, 64, data and address width.
- BASE_ADDR, 64'h0000_0000_0200_0000, base address of the CLINT region.
- TICK_DIV, 1, clock cycles per mtime increment. Must be 1 or more.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- req_valid_i  input  1  bus request valid.
- req_ready_o  output  1  block can accept a request.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  XLEN  byte address.
- req_wdata_i  input  XLEN  write data.
- req_wstrb_i  input  8  byte-enable for the write.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  requester accepts the response.
- resp_rdata_o  output  XLEN  read data.
- resp_err_o  output  1  access fault.
- mtip_o  output  1  machine timer interrupt pending.
- msip_o  output  1  machine software interrupt pending.
- mtime_o  output  XLEN  current mtime, for the time CSR.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0000 msip: only bit 0 is stored; reads return it zero-extended.
  - 0x4000 mtimecmp: 64 bits.
  - 0xBFF8 mtime: 64 bits.
- Reset values:
  - mtime = 0; mtimecmp = all-ones; msip = 0; prescaler count = 0.
  - mtip_o = 0; msip_o = 0.
  - state = IDLE; req_ready_o = 1; resp_valid_o = 0; resp_rdata_o = 0; resp_err_o = 0.
- Reset mid-transaction drops the transaction with no response.
- FSM state IDLE:
  - req_ready_o = 1.
  - A request with req_valid_i = 1 is accepted at the clock edge.
  - Write side effects take effect at that edge.
  - Read data and the error flag are captured into output registers at that edge.
  - Next state is RESP.
- FSM state RESP:
  - req_ready_o = 0; resp_valid_o = 1.
  - resp_rdata_o and resp_err_o stay stable until the edge where resp_ready_i = 1; next state is then IDLE.
- Timing and throughput:
  - Latency from acceptance to resp_valid_o is 1 cycle.
  - Only one transaction is outstanding at a time.
  - Maximum throughput is one access per 2 cycles.
- Decode and errors:
  - A request faults (resp_err_o = 1, rdata = 0, no write) if:
    - req_addr_i[2:0] != 0, or
    - the offset is not one of the three registers.
  - Addresses outside [BASE_ADDR, BASE_ADDR+0xFFFF] also fault. Upstream must route only CLINT addresses here.
- Writes:
  - Per-byte merge under req_wstrb_i.
  - msip updates from wdata[0] only when wstrb[0] = 1.
  - wstrb = 0 is a legal no-op write; the response has err = 0.
- Reads:
  - Return the register value as it was before any same-cycle tick update.
- Prescaler:
  - Counter runs 0..TICK_DIV-1. A tick is the cycle in which count = TICK_DIV-1; the count then wraps to 0.
  - mtime increments by 1 on each tick. mtime wraps from all-ones to 0 with no flag.
- Simultaneous tick and write to mtime:
  - The written bytes win; unwritten bytes take the incremented value.
  - The prescaler is not reset by the write.
- mtip_o:
  - Registered. mtip_o at cycle n+1 = (mtime >= mtimecmp, unsigned) at cycle n.
  - It clears one cycle after software raises mtimecmp above mtime.
- msip_o = msip register.
- mtime_o = mtime register.

Test Plan:
- Reset, then read 0xBFF8 twice, 2 cycles apart, with TICK_DIV = 1 -> values differ by 2; err = 0; resp_valid_o rises exactly 1 cycle after acceptance.
- Write mtimecmp = 0x20 and mtime = 0x1E, then idle -> mtip_o = 0 until mtime = 0x20; mtip_o = 1 the cycle after. Then write mtimecmp = 0x100 -> mtip_o = 0 one cycle after the write edge.
- Write 0x0 with wdata = 0xFFFF_FFFF_FFFF_FFFF and wstrb = 0x01 -> msip_o = 1 and a read returns 0x1. Write wdata = 0 with wstrb = 0x00 -> msip_o stays 1.
- Write mtime = 0xFFFF_FFFF_FFFF_FFFE -> after 2 ticks mtime reads 0 (wrap); mtip_o follows the new compare value.
- Access offset 0x0008, then address 0x4004 -> both respond with resp_err_o = 1 and rdata = 0; register state is unchanged.
- Hold resp_ready_i = 0 for 5 cycles with req_valid_i held high -> response stays stable, req_ready_o = 0, and the second request is accepted only after the response handshake. With TICK_DIV = 4, mtime advances once every 4 cycles throughout.

Source files
------------

// File: rtl/clint_if.sv
// clint_if: request/response bus between a data-memory master and the CLINT.
//   slave  modport: used by clint_timer (accepts requests, returns responses).
//   master modport: used by the requester (core LSU or testbench).
//   Signals: req_valid_i/req_ready_o/req_we_i/req_addr_i/req_wdata_i/req_wstrb_i,
//            resp_valid_o/resp_ready_i/resp_rdata_o/resp_err_o.
interface clint_if #(
   parameter int unsigned XLEN = 64
) ();
   logic            req_valid_i;
   logic            req_ready_o;
   logic            req_we_i;
   logic [XLEN-1:0] req_addr_i;
   logic [XLEN-1:0] req_wdata_i;
   logic [7:0]      req_wstrb_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] resp_rdata_o;
   logic            resp_err_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );
endinterface

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor register block (msip, mtimecmp, mtime).
//   clk, rst   : clock, synchronous active-high reset.
//   bus        : clint_if.slave request/response port, one transaction outstanding.
//   mtip_o     : machine timer interrupt pending (registered mtime >= mtimecmp).
//   msip_o     : machine software interrupt pending (msip register bit 0).
//   mtime_o    : current mtime, feeds the time CSR.
module clint_timer #(
   parameter int unsigned    XLEN      = 64,
   parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(64'h0000_0000_0200_0000),
   parameter int unsigned    TICK_DIV  = 1
) (
   input  logic            clk,
   input  logic            rst,
   clint_if.slave          bus,
   output logic            mtip_o,
   output logic            msip_o,
   output logic [XLEN-1:0] mtime_o
);

   localparam int unsigned NBYTES = XLEN / 8;
   localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [15:0] OFF_MSIP     = 16'h0000;
   localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
   localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

   typedef enum logic {IDLE, RESP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  presc_cnt;
   logic [XLEN-1:0]   mtime;
   logic [XLEN-1:0]   mtimecmp;
   logic              msip;

   logic [XLEN-1:0]   offset;
   logic              in_range;
   logic              aligned;
   logic              hit_msip;
   logic              hit_cmp;
   logic              hit_time;
   logic              addr_err;
   logic [XLEN-1:0]   wmask;
   logic [XLEN-1:0]   rd_val;
   logic              tick;
   logic              accept;
   logic              wr_en;
   logic [XLEN-1:0]   mtime_inc;
   logic [XLEN-1:0]   mtime_nx;
   logic [XLEN-1:0]   mtimecmp_nx;
   logic              msip_nx;

   // Address decode: offset relative to the base, region is 64 KiB.
   always_comb begin
      offset   = bus.req_addr_i - BASE_ADDR;
      in_range = (offset[XLEN-1:16] == '0);
      aligned  = (bus.req_addr_i[2:0] == 3'b000);
      hit_msip = in_range && aligned && (offset[15:0] == OFF_MSIP);
      hit_cmp  = in_range && aligned && (offset[15:0] == OFF_MTIMECMP);
      hit_time = in_range && aligned && (offset[15:0] == OFF_MTIME);
      addr_err = !(hit_msip || hit_cmp || hit_time);
   end

   // Byte-lane write mask from the strobes.
   always_comb begin
      wmask = '0;
      for (int i = 0; i < NBYTES; i++) begin
         wmask[i*8 +: 8] = {8{bus.req_wstrb_i[i]}};
      end
   end

   // Read mux uses pre-update register values.
   always_comb begin
      rd_val = '0;
      if (hit_msip) begin
         rd_val = XLEN'(msip);
      end else if (hit_cmp) begin
         rd_val = mtimecmp;
      end else if (hit_time) begin
         rd_val = mtime;
      end
   end

   // Next register values: tick increment first, then written bytes override it.
   always_comb begin
      tick      = (presc_cnt == CNT_W'(TICK_DIV - 1));
      accept    = (state == IDLE) && bus.req_valid_i;
      wr_en     = accept && bus.req_we_i && !addr_err;
      mtime_inc = tick ? (mtime + XLEN'(1)) : mtime;

      mtime_nx    = mtime_inc;
      mtimecmp_nx = mtimecmp;
      msip_nx     = msip;
      if (wr_en && hit_time) begin
         mtime_nx = (mtime_inc & ~wmask) | (bus.req_wdata_i & wmask);
      end
      if (wr_en && hit_cmp) begin
         mtimecmp_nx = (mtimecmp & ~wmask) | (bus.req_wdata_i & wmask);
      end
      if (wr_en && hit_msip && bus.req_wstrb_i[0]) begin
         msip_nx = bus.req_wdata_i[0];
      end
   end

   // Registers, prescaler, interrupt flags and the bus FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         presc_cnt        <= '0;
         mtime            <= '0;
         mtimecmp         <= '1;
         msip             <= 1'b0;
         mtip_o           <= 1'b0;
         bus.req_ready_o  <= 1'b1;
         bus.resp_valid_o <= 1'b0;
         bus.resp_rdata_o <= '0;
         bus.resp_err_o   <= 1'b0;
      end else begin
         presc_cnt <= tick ? '0 : (presc_cnt + CNT_W'(1));
         mtime     <= mtime_nx;
         mtimecmp  <= mtimecmp_nx;
         msip      <= msip_nx;
         mtip_o    <= (mtime >= mtimecmp);

         case (state)
            IDLE: begin
               if (accept) begin
                  // Writes and faults return zero data.
                  bus.resp_rdata_o <= (bus.req_we_i || addr_err) ? '0 : rd_val;
                  bus.resp_err_o   <= addr_err;
                  bus.resp_valid_o <= 1'b1;
                  bus.req_ready_o  <= 1'b0;
                  state            <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_ready_i) begin
                  bus.resp_valid_o <= 1'b0;
                  bus.req_ready_o  <= 1'b1;
                  state            <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign msip_o  = msip;
   assign mtime_o = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: drives two clint_timer instances (TICK_DIV 1 and 4) with the
// same bus traffic and checks both against a behavioural register model.
module tb_clint_timer;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_ready;

   logic        mtip1, msip1, mtip4, msip4;
   logic [63:0] mtime1, mtime4;

   int checks = 0;
   int errors = 0;

   clint_if #(.XLEN(64)) bus1 ();
   clint_if #(.XLEN(64)) bus4 ();

   assign bus1.req_valid_i  = req_valid;
   assign bus1.req_we_i     = req_we;
   assign bus1.req_addr_i   = req_addr;
   assign bus1.req_wdata_i  = req_wdata;
   assign bus1.req_wstrb_i  = req_wstrb;
   assign bus1.resp_ready_i = resp_ready;
   assign bus4.req_valid_i  = req_valid;
   assign bus4.req_we_i     = req_we;
   assign bus4.req_addr_i   = req_addr;
   assign bus4.req_wdata_i  = req_wdata;
   assign bus4.req_wstrb_i  = req_wstrb;
   assign bus4.resp_ready_i = resp_ready;

   clint_timer #(.XLEN(64), .BASE_ADDR(BASE), .TICK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave),
      .mtip_o(mtip1), .msip_o(msip1), .mtime_o(mtime1)
   );

   clint_timer #(.XLEN(64), .BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave),
      .mtip_o(mtip4), .msip_o(msip4), .mtime_o(mtime4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0: div 1, index 1: div 4) ----------------
   int unsigned DIV [2] = '{1, 4};
   logic [63:0] m_mtime [2];
   logic [63:0] m_cmp   [2];
   logic [63:0] m_rdata [2];
   bit          m_msip  [2];
   bit          m_mtip  [2];
   bit          m_busy  [2];
   bit          m_err   [2];
   int unsigned m_cnt   [2];
   bit          m_init = 0;

   task automatic model_step(input int k);
      logic [63:0] off, mask, nt, nc;
      bit ok, tk;
      if (rst) begin
         m_mtime[k] = 64'd0;   m_cmp[k]  = '1;   m_msip[k] = 0;  m_mtip[k] = 0;
         m_busy[k]  = 0;       m_err[k]  = 0;    m_rdata[k] = 64'd0; m_cnt[k] = 0;
         m_init = 1;
         return;
      end
      tk = (m_cnt[k] == DIV[k] - 1);
      nt = m_mtime[k] + (tk ? 64'd1 : 64'd0);
      nc = m_cmp[k];
      m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
      m_mtip[k] = (m_mtime[k] >= m_cmp[k]);
      if (!m_busy[k] && req_valid) begin
         off = req_addr - BASE;
         ok  = (off < 64'h1_0000) && (req_addr % 8 == 0) &&
               (off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
         mask = '0;
         for (int b = 0; b < 8; b++) if (req_wstrb[b]) mask[b*8 +: 8] = 8'hFF;
         m_err[k] = !ok;
         m_rdata[k] = 64'd0;
         if (ok && !req_we)
            m_rdata[k] = (off == 64'h0) ? 64'(m_msip[k]) : (off == 64'h4000) ? m_cmp[k] : m_mtime[k];
         if (ok && req_we) begin
            if (off == 64'hBFF8) nt = (nt & ~mask) | (req_wdata & mask);
            if (off == 64'h4000) nc = (nc & ~mask) | (req_wdata & mask);
            if (off == 64'h0 && req_wstrb[0]) m_msip[k] = req_wdata[0];
         end
         m_busy[k] = 1;
      end else if (m_busy[k] && resp_ready) begin
         m_busy[k] = 0;
      end
      m_mtime[k] = nt;
      m_cmp[k]   = nc;
   endtask

   // Every cycle: compare both DUTs to the model, then advance the model.
   always @(negedge clk) begin
      if (m_init) begin
         chk("d1.ready", 64'(bus1.req_ready_o),  64'(!m_busy[0]));
         chk("d1.valid", 64'(bus1.resp_valid_o), 64'(m_busy[0]));
         chk("d1.rdata", bus1.resp_rdata_o,      m_rdata[0]);
         chk("d1.err",   64'(bus1.resp_err_o),   64'(m_err[0]));
         chk("d1.mtip",  64'(mtip1),             64'(m_mtip[0]));
         chk("d1.msip",  64'(msip1),             64'(m_msip[0]));
         chk("d1.mtime", mtime1,                 m_mtime[0]);
         chk("d4.ready", 64'(bus4.req_ready_o),  64'(!m_busy[1]));
         chk("d4.valid", 64'(bus4.resp_valid_o), 64'(m_busy[1]));
         chk("d4.rdata", bus4.resp_rdata_o,      m_rdata[1]);
         chk("d4.err",   64'(bus4.resp_err_o),   64'(m_err[1]));
         chk("d4.mtip",  64'(mtip4),             64'(m_mtip[1]));
         chk("d4.msip",  64'(msip4),             64'(m_msip[1]));
         chk("d4.mtime", mtime4,                 m_mtime[1]);
      end
      model_step(0);
      model_step(1);
   end

   // One bus transaction; observed response taken from the TICK_DIV=1 instance.
   task automatic access(input bit w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input int hold,
                         output logic [63:0] rd, output logic e);
      bit got = 0;
      req_valid = 1; req_we = w; req_addr = a; req_wdata = d; req_wstrb = s;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (bus1.req_ready_o) got = 1;
      end
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout: got no acceptance expected acceptance within 50 cycles");
      end
      @(posedge clk); #1;
      req_valid = 0;
      if (hold > 0) resp_ready = 0;
      @(negedge clk);
      chk("resp_latency", 64'(bus1.resp_valid_o), 64'd1);
      rd = bus1.resp_rdata_o;
      e  = bus1.resp_err_o;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1 resp_ready = 1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] r1, r2, t0;
      logic        e1;
      bit          found;
      rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset values and mtime progression between back-to-back reads.
      access(0, BASE + 64'hBFF8, 0, 0, 0, r1, e1);
      chk("mtime_rd1_err", 64'(e1), 64'd0);
      access(0, BASE + 64'hBFF8, 0, 0, 0, r2, e1);
      chk("mtime_delta", r2 - r1, 64'd2);
      access(0, BASE + 64'h4000, 0, 0, 0, r1, e1);
      chk("mtimecmp_reset", r1, 64'hFFFF_FFFF_FFFF_FFFF);
      access(0, BASE, 0, 0, 0, r1, e1);
      chk("msip_reset", r1, 64'd0);

      // Timer interrupt assertion and clearing.
      access(1, BASE + 64'h4000, 64'h20, 8'hFF, 0, r1, e1);
      access(1, BASE + 64'hBFF8, 64'h1E, 8'hFF, 0, r1, e1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (mtime1 == 64'h20) found = 1;
      end
      chk("mtime_reached_20", 64'(found), 64'd1);
      chk("mtip_before", 64'(mtip1), 64'd0);
      @(negedge clk);
      chk("mtip_after", 64'(mtip1), 64'd1);
      access(1, BASE + 64'h4000, 64'h100, 8'hFF, 0, r1, e1);
      @(negedge clk);
      chk("mtip_cleared", 64'(mtip1), 64'd0);

      // Software interrupt bit.
      access(1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 0, r1, e1);
      chk("msip_set", 64'(msip1), 64'd1);
      access(0, BASE, 0, 0, 0, r1, e1);
      chk("msip_read", r1, 64'd1);
      access(1, BASE, 64'd0, 8'h00, 0, r1, e1);
      chk("wstrb0_err", 64'(e1), 64'd0);
      chk("msip_kept", 64'(msip1), 64'd1);

      // mtime wrap.
      access(1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r1, e1);
      @(negedge clk);
      chk("mtime_ff", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("mtime_wrap", mtime1, 64'd0);
      access(1, BASE + 64'h4000, 64'h10, 8'hFF, 0, r1, e1);

      // Faulting accesses.
      access(0, BASE + 64'h0008, 0, 0, 0, r1, e1);
      chk("err_off8", 64'(e1), 64'd1);
      chk("err_off8_rdata", r1, 64'd0);
      access(1, BASE + 64'h4004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r1, e1);
      chk("err_misalign", 64'(e1), 64'd1);
      chk("err_misalign_rdata", r1, 64'd0);
      access(0, BASE + 64'h4000, 0, 0, 0, r1, e1);
      chk("cmp_unchanged", r1, 64'h10);

      // Backpressure with a second request held pending.
      req_valid = 1; req_we = 0; req_addr = BASE + 64'hBFF8; req_wstrb = 0;
      @(negedge clk);
      @(posedge clk); #1;
      resp_ready = 0; req_addr = BASE + 64'h4000;
      @(negedge clk);
      r1 = bus1.resp_rdata_o;
      t0 = mtime4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(bus1.req_ready_o), 64'd0);
         chk("bp_rdata_stable", bus1.resp_rdata_o, r1);
      end
      chk("div4_step", mtime4 - t0, 64'd1);
      resp_ready = 1;
      @(negedge clk);
      chk("bp_ready_back", 64'(bus1.req_ready_o), 64'd1);
      @(negedge clk);
      chk("bp_second_rdata", bus1.resp_rdata_o, 64'h10);
      req_valid = 0;
      @(posedge clk); #1;

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic [63:0] a;
         case ($urandom_range(7))
            0: a = BASE;
            1: a = BASE + 64'h4000;
            2, 3: a = BASE + 64'hBFF8;
            4: a = BASE + 64'h8;
            5: a = BASE + 64'h4000 + 64'($urandom_range(7));
            6: a = BASE + 64'h1_0000;
            default: a = {$urandom, $urandom};
         endcase
         access($urandom_range(1), a, {$urandom, $urandom}, 8'($urandom),
                int'($urandom_range(3)), r1, e1);
         repeat ($urandom_range(2)) @(posedge clk);
         #1;
      end

      // Reset in the middle of a transaction drops the response.
      req_valid = 1; req_we = 0; req_addr = BASE + 64'hBFF8;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_drop_valid", 64'(bus1.resp_valid_o), 64'd0);
      chk("rst_mtime", mtime1, 64'd0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
